cla_seq_ctrl: RTL
=================

// Module: cla_seq_ctrl
// PURPOSE
//  Sequencer that adds WIDTH-bit operands by reusing one 4-bit carry-lookahead
//  slice, one nibble per clock. The nibble carry is registered between cycles.
//  Sits between a requester (start/done handshake) and wide-operand datapaths
//  where a full-width CLA is too large. Result is held stable until the next op.
// PARAMETERS
//  WIDTH  16  operand/sum width in bits; must be a multiple of 4, >= 4
//  NIB    WIDTH/4 (localparam)  nibble count = RUN cycles per operation
// PORTS
//  clk    in   1      single clock, rising edge
//  rst    in   1      synchronous, active-high reset
//  start  in   1      request; sampled only in IDLE
//  a      in   WIDTH  operand A, captured with accepted start
//  b      in   WIDTH  operand B, captured with accepted start
//  cin    in   1      carry-in, captured with accepted start
//  sub    in   1      subtract select (present only with CLA_SEQ_SUB_EN)
//  busy   out  1      high while in RUN
//  done   out  1      one-cycle pulse, high in DONE
//  sum    out  WIDTH  registered result
//  cout   out  1      registered carry out of MSB nibble
// BEHAVIOUR
//  - Reset: state=IDLE; busy=0, done=0, sum=0, cout=0; idx, carry, op regs=0.
//  - Reset has priority in every state; aborts RUN with no done pulse.
//  - FSM: IDLE -(start)-> RUN -(idx==NIB-1)-> DONE -> IDLE (unconditional).
//  - IDLE, start=1 at edge k: latch a,b,carry<=cin; idx<=0; go RUN.
//  - RUN, each edge: nibble n=idx of a_r,b_r through the 4-bit lookahead slice:
//    g[i]=a&b, p[i]=a|b, c0=carry, c[i+1]=g[i]|p[i]&c[i], all 4 carries
//    flat two-level (no ripple); s[i]=a^b^c[i]; write s to work[4n+3:4n];
//    carry<=c4; idx<=idx+1.
//  - On last RUN edge (idx==NIB-1): sum<=full work incl. final nibble,
//    cout<=c4, go DONE. sum/cout change only on this edge, never mid-op.
//  - Timing: busy=1 for cycles k+1..k+NIB; done=1 in cycle k+NIB+1 only.
//    Total latency start->done = NIB+1 edges (5 for WIDTH=16).
//  - start while busy or done: ignored, not queued; a/b/cin changes then ignored.
//  - Earliest next accept: IDLE cycle after DONE (start held high -> new op).
//  - Width: arithmetic is modulo 2^WIDTH; overflow only via cout.
//  - idx width = clog2(NIB), min 1 bit; no wrap beyond NIB-1.
// CONFIGURATION
//  CLA_SEQ_SUB_EN defined: port sub exists; captured with start; if sub=1,
//    b_r<=~b and carry<=1 (cin ignored), giving a-b; cout=1 means no borrow.
//  CLA_SEQ_SUB_EN undefined: no sub port; always a+b+cin.
// TESTING (WIDTH=16)
//  - a=FFFF b=0001 cin=0 start@k -> busy k+1..k+4, done@k+5, sum=0000 cout=1.
//  - a=1234 b=4321 cin=1 -> sum=5556 cout=0; sum stays 0000 until done edge.
//  - start pulsed again at k+2 with a=0 b=0 -> ignored; result of first op only.
//  - rst=1 at k+2 mid-RUN -> next cycle busy=0 done=0 sum=0 cout=0, IDLE,
//    no done pulse.
//  - start held high -> ops back-to-back, done every 6 cycles, each fresh a/b.
//  - SUB_EN: a=0005 b=0007 sub=1 cin=0 -> sum=FFFE cout=0; a=0007 b=0005
//    -> sum=0002 cout=1.

Source files
------------

// File: rtl/cla_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : cla_seq_ctrl
// Description : Multi-cycle WIDTH-bit adder. One 4-bit carry-lookahead slice
//               is reused once per clock, one nibble per clock, and the
//               nibble carry is registered between cycles. Requests use a
//               start/done handshake. The result holds until the next
//               operation completes.
//               Optional feature macro: CLA_SEQ_SUB_EN. When it is defined,
//               the block has a sub port, and sub=1 computes a-b.
// Revision    : 1.0 - initial release
// ============================================================================
module cla_seq_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef CLA_SEQ_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int NIB   = WIDTH / 4;
  localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic               r_carry;
  logic [IDX_W-1:0]   r_idx;
  logic [WIDTH-1:0]   r_work;
  logic [WIDTH-1:0]   w_work_next;
  logic [IDX_W+1:0]   w_sh;
  logic [3:0]         w_an;
  logic [3:0]         w_bn;
  logic [3:0]         w_g;
  logic [3:0]         w_p;
  logic [4:0]         w_c;
  logic [3:0]         w_s;
  logic               w_accept;
  logic               w_last;
  logic [WIDTH-1:0]   w_b_cap;
  logic               w_c_cap;

  // Bit offset of the active nibble within the operands.
  assign w_sh = {r_idx, 2'b00};
  assign w_an = r_a[w_sh +: 4];
  assign w_bn = r_b[w_sh +: 4];

  // Two-level carry lookahead. Every carry is a flat sum of products of
  // g, p and the incoming nibble carry, so nothing ripples inside the slice.
  assign w_g    = w_an & w_bn;
  assign w_p    = w_an | w_bn;
  assign w_c[0] = r_carry;
  assign w_c[1] = w_g[0] | (w_p[0] & r_carry);
  assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & r_carry);
  assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & r_carry);
  assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & r_carry);
  assign w_s    = w_an ^ w_bn ^ w_c[3:0];

  assign w_accept = (r_state == ST_IDLE) && start;
  assign w_last   = (r_idx == LAST_IDX);

  // Operand B and the carry-in as they are captured on an accepted start.
  // For subtraction, B is inverted and the carry-in is forced to 1.
`ifdef CLA_SEQ_SUB_EN
  assign w_b_cap = sub ? ~b : b;
  assign w_c_cap = sub ? 1'b1 : cin;
`else
  assign w_b_cap = b;
  assign w_c_cap = cin;
`endif

  // Working result with the current nibble merged in. This lets the last
  // RUN edge publish the complete sum in a single step.
  always_comb begin
    w_work_next = r_work;
    w_work_next[w_sh +: 4] = w_s;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  // Next-state logic. DONE lasts exactly one cycle.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (start) w_state_next = ST_RUN;
      ST_RUN:  if (w_last) w_state_next = ST_DONE;
      ST_DONE: w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Datapath: capture the operands on accept, then process one nibble per
  // RUN cycle. The visible result changes only on the final RUN edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_idx   <= '0;
      r_work  <= '0;
      sum     <= '0;
      cout    <= 1'b0;
    end else if (w_accept) begin
      r_a     <= a;
      r_b     <= w_b_cap;
      r_carry <= w_c_cap;
      r_idx   <= '0;
    end else if (r_state == ST_RUN) begin
      r_work  <= w_work_next;
      r_carry <= w_c[4];
      if (w_last) begin
        sum  <= w_work_next;
        cout <= w_c[4];
      end else begin
        r_idx <= r_idx + 1'b1;
      end
    end
  end

  assign busy = (r_state == ST_RUN);
  assign done = (r_state == ST_DONE);

endmodule
`default_nettype wire
